// File: rtl/dsp_mac_engine.sv
// Three-stage multiply-accumulate slice: operand register, pre-adder and multiplier,
// then post-adder with saturation and pattern detect. Width and signedness are set by parameters.
module dsp_mac_engine #(
    parameter int             A_W     = 18,
    parameter int             B_W     = 18,
    parameter int             P_W     = 48,
    parameter bit             SIGNED  = 1'b1,
    parameter bit             SAT_EN  = 1'b1,
    parameter logic [P_W-1:0] PATTERN = '0,
    parameter logic [P_W-1:0] MASK    = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    input  logic [B_W-1:0]       d,
    input  logic [P_W-1:0]       c,
    input  logic [P_W-1:0]       pcin,
    input  logic                 preadd_en,
    input  logic                 preadd_sub,
    input  logic [1:0]           zsel,
    input  logic                 post_sub,
    input  logic                 carryin,
    output logic [A_W+B_W:0]     m,
    output logic [P_W-1:0]       p,
    output logic [P_W-1:0]       pcout,
    output logic                 out_valid,
    output logic                 overflow,
    output logic                 pattern_det
);
    localparam int M_W = A_W + B_W + 1;

    function automatic logic [B_W:0] ext_b(input logic [B_W-1:0] v);
        return {(SIGNED ? v[B_W-1] : 1'b0), v};
    endfunction

    function automatic logic [B_W:0] pre_add(input logic [B_W-1:0] dv, input logic [B_W-1:0] bv,
                                             input logic sub);
        return sub ? (ext_b(dv) - ext_b(bv)) : (ext_b(dv) + ext_b(bv));
    endfunction

    // Both operands are extended to the full product width, so the low M_W bits
    // of a plain multiply are the correct result in either signedness.
    function automatic logic [M_W-1:0] mul(input logic [A_W-1:0] av, input logic [B_W:0] bv);
        logic [M_W-1:0] ax;
        logic [M_W-1:0] bx;
        ax = {{(M_W-A_W){(SIGNED ? av[A_W-1] : 1'b0)}}, av};
        bx = {{(M_W-B_W-1){(SIGNED ? bv[B_W] : 1'b0)}}, bv};
        return ax * bx;
    endfunction

    function automatic logic [P_W:0] post_add(input logic [P_W-1:0] z, input logic [M_W-1:0] mv,
                                              input logic sub, input logic cin);
        logic [P_W:0] zx;
        logic [P_W:0] mx;
        logic [P_W:0] cx;
        zx = {(SIGNED ? z[P_W-1] : 1'b0), z};
        mx = {{(P_W+1-M_W){(SIGNED ? mv[M_W-1] : 1'b0)}}, mv};
        cx = {{P_W{1'b0}}, cin};
        return sub ? (zx - mx - cx) : (zx + mx + cx);
    endfunction

    // Returns {overflow, value}; the value is clamped only when SAT_EN is set.
    function automatic logic [P_W:0] saturate(input logic [P_W:0] r, input logic sub);
        logic           ovf;
        logic [P_W-1:0] clamp;
        if (SIGNED) begin
            ovf   = r[P_W] ^ r[P_W-1];
            clamp = r[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
        end else begin
            ovf   = r[P_W];
            clamp = sub ? '0 : '1;
        end
        return {ovf, ((ovf && SAT_EN) ? clamp : r[P_W-1:0])};
    endfunction

    logic [A_W-1:0] a_p1;
    logic [B_W-1:0] b_p1, d_p1;
    logic [P_W-1:0] c_p1;
    logic           preadd_en_p1, preadd_sub_p1, post_sub_p1, carryin_p1, vld_p1;
    logic [1:0]     zsel_p1;

    logic [M_W-1:0] m_p2;
    logic [P_W-1:0] c_p2;
    logic           post_sub_p2, carryin_p2, vld_p2;
    logic [1:0]     zsel_p2;

    logic [P_W-1:0] p_p3;
    logic           ovf_p3, pat_p3, vld_p3;

    logic [B_W:0]   mb_p1;
    logic [M_W-1:0] prod_p1;
    logic [P_W-1:0] z_p2;
    logic [P_W:0]   sat_p2;
    logic           pat_hit_p2;

    always_comb begin
        mb_p1   = preadd_en_p1 ? pre_add(d_p1, b_p1, preadd_sub_p1) : ext_b(b_p1);
        prod_p1 = mul(a_p1, mb_p1);
        z_p2    = '0;
        case (zsel_p2)
            2'd1:    z_p2 = pcin;
            2'd2:    z_p2 = p_p3;
            2'd3:    z_p2 = c_p2;
            default: z_p2 = '0;
        endcase
        sat_p2     = saturate(post_add(z_p2, m_p2, post_sub_p2, carryin_p2), post_sub_p2);
        pat_hit_p2 = (((sat_p2[P_W-1:0] ^ PATTERN) & ~MASK) == '0);
    end

    // Stage 1: operand and control capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_p1 <= '0; b_p1 <= '0; d_p1 <= '0; c_p1 <= '0;
            preadd_en_p1 <= 1'b0; preadd_sub_p1 <= 1'b0; zsel_p1 <= '0;
            post_sub_p1 <= 1'b0; carryin_p1 <= 1'b0; vld_p1 <= 1'b0;
        end else if (ce) begin
            a_p1 <= a; b_p1 <= b; d_p1 <= d; c_p1 <= c;
            preadd_en_p1 <= preadd_en; preadd_sub_p1 <= preadd_sub; zsel_p1 <= zsel;
            post_sub_p1 <= post_sub; carryin_p1 <= carryin; vld_p1 <= in_valid;
        end
    end

    // Stage 2: pre-adder and product
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_p2 <= '0; c_p2 <= '0; zsel_p2 <= '0;
            post_sub_p2 <= 1'b0; carryin_p2 <= 1'b0; vld_p2 <= 1'b0;
        end else if (ce) begin
            m_p2 <= prod_p1; c_p2 <= c_p1; zsel_p2 <= zsel_p1;
            post_sub_p2 <= post_sub_p1; carryin_p2 <= carryin_p1; vld_p2 <= vld_p1;
        end
    end

    // Stage 3: post-adder; bubbles leave the accumulator untouched
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_p3 <= '0; ovf_p3 <= 1'b0; pat_p3 <= 1'b0; vld_p3 <= 1'b0;
        end else if (ce) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                p_p3   <= sat_p2[P_W-1:0];
                ovf_p3 <= sat_p2[P_W];
                pat_p3 <= pat_hit_p2;
            end
        end
    end

    assign m           = m_p2;
    assign p           = p_p3;
    assign pcout       = p_p3;
    assign out_valid   = vld_p3;
    assign overflow    = ovf_p3;
    assign pattern_det = pat_p3;
endmodule

// File: tb/tb_dsp_mac_engine.sv
// Directed bench for dsp_mac_engine: a saturating/pattern instance and a wrapping instance share stimulus.
module tb_dsp_mac_engine;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic [17:0] a = '0, b = '0, d = '0;
    logic [47:0] c = '0, pcin = '0;
    logic        preadd_en = 1'b0, preadd_sub = 1'b0, post_sub = 1'b0, carryin = 1'b0;
    logic [1:0]  zsel = '0;
    logic [36:0] m, m_w;
    logic [47:0] p, pcout, p_w, pcout_w;
    logic        out_valid, overflow, pattern_det;
    logic        out_valid_w, overflow_w, pattern_det_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsp_mac_engine #(.A_W(18), .B_W(18), .P_W(48), .SIGNED(1'b1), .SAT_EN(1'b1),
                     .PATTERN(48'h100), .MASK(48'hFF)) dut (
        .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
        .pcin(pcin), .preadd_en(preadd_en), .preadd_sub(preadd_sub), .zsel(zsel),
        .post_sub(post_sub), .carryin(carryin), .m(m), .p(p), .pcout(pcout),
        .out_valid(out_valid), .overflow(overflow), .pattern_det(pattern_det));

    dsp_mac_engine #(.A_W(18), .B_W(18), .P_W(48), .SIGNED(1'b1), .SAT_EN(1'b0),
                     .PATTERN(48'h0), .MASK(48'h0)) dut_wrap (
        .clk(clk), .rstn(rstn), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
        .pcin(pcin), .preadd_en(preadd_en), .preadd_sub(preadd_sub), .zsel(zsel),
        .post_sub(post_sub), .carryin(carryin), .m(m_w), .p(p_w), .pcout(pcout_w),
        .out_valid(out_valid_w), .overflow(overflow_w), .pattern_det(pattern_det_w));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; a = '0; b = '0; d = '0; c = '0;
        preadd_en = 1'b0; preadd_sub = 1'b0; zsel = 2'd0; post_sub = 1'b0; carryin = 1'b0;
    endtask

    task automatic drive(input logic [17:0] av, input logic [17:0] bv, input logic [17:0] dv,
                         input logic [47:0] cv, input logic pe, input logic ps,
                         input logic [1:0] zs, input logic psub, input logic ci);
        in_valid = 1'b1; a = av; b = bv; d = dv; c = cv;
        preadd_en = pe; preadd_sub = ps; zsel = zs; post_sub = psub; carryin = ci;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ce = 1'b1;
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({p, pcout, m, out_valid, overflow, pattern_det} !== '0) begin
            n_err++;
            $display("FAIL reset_state: p=%h m=%h ov=%b ovf=%b pd=%b want all 0",
                     p, m, out_valid, overflow, pattern_det);
        end
        do_reset();
    endtask

    task automatic test_preadd();
        do_reset();
        drive(18'd3, 18'd4, 18'd5, 48'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL preadd_early_valid1: got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (m !== 37'd27) begin n_err++; $display("FAIL preadd_m: got %0d want 27", m); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL preadd_early_valid2: got %b want 0", out_valid); end
        tick();
        n_cmp++;
        if (p !== 48'd27 || out_valid !== 1'b1 || overflow !== 1'b0) begin
            n_err++; $display("FAIL preadd_add: p=%0d v=%b ovf=%b want 27 1 0", p, out_valid, overflow);
        end
        drive(18'd3, 18'd4, 18'd5, 48'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'd3) begin n_err++; $display("FAIL preadd_sub: got %0d want 3", p); end
    endtask

    task automatic test_signed_cascade();
        pcin = 48'd10;
        drive(18'h3FFFE, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'd4) begin n_err++; $display("FAIL cascade_pcin: got %h want 4", p); end
        drive(18'h3FFFE, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'hFFFF_FFFF_FFFA || pcout !== 48'hFFFF_FFFF_FFFA) begin
            n_err++; $display("FAIL signed_neg: p=%h pcout=%h want FFFFFFFFFFFA", p, pcout);
        end
        pcin = 48'd0;
    endtask

    task automatic test_accumulate_bubbles();
        logic [47:0] exp_p [10] = '{48'd0, 48'd0, 48'd1, 48'd1, 48'd2, 48'd2, 48'd3, 48'd3, 48'd4, 48'd4};
        logic        exp_v [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if ((i % 2 == 0) && (i < 8)) drive(18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
            else idle_inputs();
            tick();
            n_cmp++;
            if (p !== exp_p[i] || out_valid !== exp_v[i]) begin
                n_err++;
                $display("FAIL accum_bubble[%0d]: p=%0d v=%b want %0d %b", i, p, out_valid, exp_p[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp_p [5] = '{48'd0, 48'd0, 48'd6, 48'd12, 48'd18};
        logic        exp_v [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(18'd2, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
            else idle_inputs();
            tick();
            n_cmp++;
            if (p !== exp_p[i] || out_valid !== exp_v[i]) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: p=%0d v=%b want %0d %b", i, p, out_valid, exp_p[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_saturation();
        drive(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'h7FFF_FFFF_FFFF || overflow !== 1'b1) begin
            n_err++; $display("FAIL sat_pos: p=%h ovf=%b want 7FFFFFFFFFFF 1", p, overflow);
        end
        n_cmp++;
        if (p_w !== 48'h8000_0000_0000 || overflow_w !== 1'b1) begin
            n_err++; $display("FAIL wrap_pos: p=%h ovf=%b want 800000000000 1", p_w, overflow_w);
        end
        drive(18'd1, 18'd1, 18'd0, 48'h8000_0000_0000, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'h8000_0000_0000 || overflow !== 1'b1) begin
            n_err++; $display("FAIL sat_neg: p=%h ovf=%b want 800000000000 1", p, overflow);
        end
        n_cmp++;
        if (p_w !== 48'h7FFF_FFFF_FFFF || overflow_w !== 1'b1) begin
            n_err++; $display("FAIL wrap_neg: p=%h ovf=%b want 7FFFFFFFFFFF 1", p_w, overflow_w);
        end
    endtask

    task automatic test_pattern();
        drive(18'd16, 18'd17, 18'd0, 48'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'h110 || pattern_det !== 1'b1 || overflow !== 1'b0) begin
            n_err++; $display("FAIL pattern_hit: p=%h pd=%b ovf=%b want 110 1 0", p, pattern_det, overflow);
        end
        drive(18'd32, 18'd16, 18'd0, 48'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'h200 || pattern_det !== 1'b0) begin
            n_err++; $display("FAIL pattern_miss: p=%h pd=%b want 200 0", p, pattern_det);
        end
    endtask

    task automatic test_ce_stall();
        logic [47:0] exp_p [4] = '{48'd2, 48'd3, 48'd4, 48'd4};
        logic        exp_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        drive(18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'd1 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_pre: p=%0d v=%b want 1 1", p, out_valid);
        end
        ce = 1'b0;
        a = 18'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (p !== 48'd1 || out_valid !== 1'b1 || m !== 37'd1) begin
                n_err++; $display("FAIL stall_hold[%0d]: p=%0d v=%b m=%0d want 1 1 1", i, p, out_valid, m);
            end
        end
        ce = 1'b1;
        a = 18'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) idle_inputs();
            n_cmp++;
            if (p !== exp_p[i] || out_valid !== exp_v[i]) begin
                n_err++;
                $display("FAIL stall_resume[%0d]: p=%0d v=%b want %0d %b", i, p, out_valid, exp_p[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (p !== 48'd2) begin n_err++; $display("FAIL rst_mid_pre: got %0d want 2", p); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({p, pcout, m, out_valid, overflow, pattern_det} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async: p=%h m=%h v=%b ovf=%b pd=%b want all 0",
                     p, m, out_valid, overflow, pattern_det);
        end
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || p !== 48'd0) begin
                n_err++; $display("FAIL rst_mid_flush[%0d]: p=%0d v=%b want 0 0", i, p, out_valid);
            end
        end
        drive(18'd1, 18'd1, 18'd0, 48'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        n_cmp++;
        if (p !== 48'd1 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_restart: p=%0d v=%b want 1 1", p, out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_preadd();
        test_signed_cascade();
        test_accumulate_bubbles();
        test_back_to_back();
        test_saturation();
        test_pattern();
        test_ce_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_mac_engine.md
# dsp_mac_engine

Parametrised multiply-accumulate slice, successor to the fixed 18x18/48-bit DSP slice. Widths and signedness are set by parameters. It adds a valid-qualified pipeline, a global clock enable, optional saturation with an overflow flag, and a registered pattern detector. It sits in DSP datapaths (FIR taps, MAC arrays) and cascades through PCIN/PCOUT.

## Interface
- A_W, 18: multiplier A operand width
- B_W, 18: B and D operand width; pre-adder width is B_W+1
- P_W, 48: C/P/PCIN/PCOUT width; must be >= A_W+B_W+1
- SIGNED, 1: 1 = two's-complement arithmetic, 0 = unsigned
- SAT_EN, 1: 1 = clamp post-adder overflow, 0 = wrap modulo 2^P_W
- PATTERN, 0: P_W-bit compare value
- MASK, all-zero: P_W-bit mask; 1 = bit ignored in the pattern compare
- CLK in 1: clock, rising edge
- RSTN in 1: reset, asynchronous, active-low
- CE in 1: global pipeline enable; 0 freezes every register
- IN_VALID in 1: qualifies the operands and controls this cycle
- A in A_W, B in B_W, D in B_W, C in P_W, PCIN in P_W: data operands
- PREADD_EN in 1: 1 = multiplier B input is the pre-adder result, 0 = B
- PREADD_SUB in 1: pre-adder computes D−B when 1, D+B when 0
- ZSEL in 2: post-adder Z operand: 0 = zero, 1 = PCIN, 2 = P (accumulate), 3 = C
- POST_SUB in 1: 1 = Z − (M + CARRYIN), 0 = Z + M + CARRYIN
- CARRYIN in 1: post-adder carry/borrow input
- M out A_W+B_W+1: registered product
- P out P_W: registered result; PCOUT out P_W: equals P
- OUT_VALID out 1: P, OVERFLOW and PATTERN_DET hold a new result
- OVERFLOW out 1: the current P was clamped (SAT_EN=1) or wrapped (SAT_EN=0)
- PATTERN_DET out 1: the current P matches PATTERN under MASK

## Operation
- Stage 1 (CE=1): registers A, B, D, C, all controls and IN_VALID into v1.
- Stage 2 (CE=1):
  - pre = D±B at B_W+1 bits, sign- or zero-extended per SIGNED.
  - mb = PREADD_EN ? pre : ext(B).
  - M ← A*mb at A_W+B_W+1 bits.
  - Controls and C pass down; v2 ← v1.
- Stage 3 (CE=1 and v2=1):
  - Z and ext(M) are computed at P_W+1 bits; CARRYIN is added, or included in the subtrahend when POST_SUB=1.
  - P ← result; OVERFLOW ← overflow; PATTERN_DET ← (((result ^ PATTERN) & ~MASK) == 0).
- Stage 3 with v2=0: P, OVERFLOW and PATTERN_DET hold, so a bubble never disturbs the accumulator.
- OUT_VALID ← v2 on every CE=1 edge.
- Overflow, signed: the P_W+1-bit result does not fit in P_W bits. Clamp to 0x7F..F on positive overflow, 0x80..0 on negative.
- Overflow, unsigned: carry-out on add clamps to all-ones; borrow on subtract clamps to 0.
- With SAT_EN=0, P keeps the low P_W bits and OVERFLOW still flags the event.
- PATTERN_DET compares the post-saturation value.
- ZSEL=2 uses the current P register, which is the last valid result.

## Timing
- Latency 3 CE-active edges: operands sampled at edge k appear on P with OUT_VALID=1 after edge k+2.
- Full throughput: one result per cycle with back-to-back accumulation.
- CE=0: all state holds, including v1, v2, OUT_VALID, P and M; no results are lost or duplicated.
- RSTN=0 (async, any time, including mid-accumulation):
  - All stage registers, v1, v2, M, P, PCOUT, OUT_VALID, OVERFLOW and PATTERN_DET go to 0 immediately.
  - In-flight samples are discarded.
  - After release, the first OUT_VALID appears 3 CE-active edges after the first IN_VALID=1.
- Simultaneous accumulate and new sample: the Z=P operand is the P value before the edge.

## Test plan
- Pre-adder: A=3, D=5, B=4, PREADD_EN=1, PREADD_SUB=0, ZSEL=0 -> M=27, P=27, OUT_VALID=1 exactly 3 edges later. With PREADD_SUB=1 -> P=3.
- Signed and cascade: A=−2, B=3, ZSEL=1, PCIN=10 -> P=4. With A=−2, ZSEL=0 -> P=0xFFFF_FFFF_FFFA.
- Accumulate with bubbles: after reset, 4 valid samples A=1, B=1, ZSEL=2 with IN_VALID=0 gaps between them -> P = 1, 2, 3, 4; P unchanged in the gap cycles.
- Saturation: C=0x7FFF_FFFF_FFFF, A=1, B=1, ZSEL=3 -> P=0x7FFF_FFFF_FFFF, OVERFLOW=1. With SAT_EN=0 -> P=0x8000_0000_0000, OVERFLOW=1.
- Pattern detect: PATTERN=0x100, MASK=0xFF, A=16, B=17 (product 0x110) -> PATTERN_DET=1. With A=32, B=16 (product 0x200) -> PATTERN_DET=0.
- CE stall and reset: CE=0 for 5 cycles mid-stream -> outputs frozen, then the sequence resumes intact. RSTN pulsed low mid-accumulation -> all outputs 0 immediately, and the next accumulation restarts from 0.
